// File: rtl/alu_op_sequencer_if.sv
// Handshake and ALU-side bundle for alu_op_sequencer: request in, ALU drive/return, result out.
// The sequencer uses the slave modport; the issuing stage (and the ALU return) use master.
interface alu_op_sequencer_if;
    logic        in_valid_i;
    logic        in_ready_o;
    logic        is_rtype_i;
    logic [2:0]  funct3_i;
    logic [6:0]  funct7_i;
    logic [31:0] rs1_val_i;
    logic [31:0] rs2_val_i;
    logic [31:0] imm_i;
    logic [31:0] alu_operand1_o;
    logic [31:0] alu_operand2_o;
    logic [3:0]  alu_ctrl_o;
    logic [31:0] alu_result_i;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [31:0] result_o;
    logic        illegal_o;

    modport slave (
        input  in_valid_i, is_rtype_i, funct3_i, funct7_i, rs1_val_i, rs2_val_i, imm_i,
        input  alu_result_i, out_ready_i,
        output in_ready_o, alu_operand1_o, alu_operand2_o, alu_ctrl_o,
        output out_valid_o, result_o, illegal_o
    );

    modport master (
        output in_valid_i, is_rtype_i, funct3_i, funct7_i, rs1_val_i, rs2_val_i, imm_i,
        output alu_result_i, out_ready_i,
        input  in_ready_o, alu_operand1_o, alu_operand2_o, alu_ctrl_o,
        input  out_valid_o, result_o, illegal_o
    );
endinterface

// File: rtl/alu_op_sequencer.sv
// Issue-side driver for the combinational ALU: decodes OP/OP-IMM funct fields, holds registered
// operands/control on the ALU for 1 cycle (MUL_CYCLES for MUL) and returns the captured result.
module alu_op_sequencer #(
    parameter int unsigned MUL_CYCLES = 3
) (
    input logic               clk_i,
    input logic               rst_i,
    alu_op_sequencer_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic [3:0] CTRL_AND     = 4'b0000;
    localparam logic [3:0] CTRL_XOR     = 4'b0001;
    localparam logic [3:0] CTRL_ADD     = 4'b0010;
    localparam logic [3:0] CTRL_SLL     = 4'b0011;
    localparam logic [3:0] CTRL_SUB     = 4'b0110;
    localparam logic [3:0] CTRL_SRA     = 4'b0111;
    localparam logic [3:0] CTRL_MUL     = 4'b1000;
    localparam logic [3:0] CTRL_ILLEGAL = 4'b1111;
    localparam logic [3:0] MUL_LOAD     = 4'(MUL_CYCLES - 1);

    localparam logic [6:0] F7_ZERO = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;
    localparam logic [6:0] F7_MUL  = 7'b0000001;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] op1_q, op1_d;
    logic [31:0] op2_q, op2_d;
    logic [3:0]  ctrl_q, ctrl_d;
    logic        flag_q, flag_d;
    logic [31:0] result_q, result_d;
    logic        illegal_q, illegal_d;

    logic [3:0]  dec_ctrl;
    logic        dec_illegal;
    logic        f7_zero_or_imm;

    // OP-IMM has no funct7, so AND/XOR accept any upper immediate bits there.
    always_comb begin
        dec_ctrl       = CTRL_ILLEGAL;
        dec_illegal    = 1'b1;
        f7_zero_or_imm = !bus.is_rtype_i || (bus.funct7_i == F7_ZERO);
        case (bus.funct3_i)
            3'b000: begin
                if (f7_zero_or_imm) begin
                    dec_ctrl    = CTRL_ADD;
                    dec_illegal = 1'b0;
                end else if (bus.funct7_i == F7_ALT) begin
                    dec_ctrl    = CTRL_SUB;
                    dec_illegal = 1'b0;
                end else if (bus.funct7_i == F7_MUL) begin
                    dec_ctrl    = CTRL_MUL;
                    dec_illegal = 1'b0;
                end
            end
            3'b111: begin
                if (f7_zero_or_imm) begin
                    dec_ctrl    = CTRL_AND;
                    dec_illegal = 1'b0;
                end
            end
            3'b100: begin
                if (f7_zero_or_imm) begin
                    dec_ctrl    = CTRL_XOR;
                    dec_illegal = 1'b0;
                end
            end
            3'b001: begin
                if (bus.funct7_i == F7_ZERO) begin
                    dec_ctrl    = CTRL_SLL;
                    dec_illegal = 1'b0;
                end
            end
            3'b101: begin
                if (bus.funct7_i == F7_ALT) begin
                    dec_ctrl    = CTRL_SRA;
                    dec_illegal = 1'b0;
                end
            end
            default: begin
                dec_ctrl    = CTRL_ILLEGAL;
                dec_illegal = 1'b1;
            end
        endcase
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op1_d     = op1_q;
        op2_d     = op2_q;
        ctrl_d    = ctrl_q;
        flag_d    = flag_q;
        result_d  = result_q;
        illegal_d = illegal_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid_i) begin
                    op1_d   = bus.rs1_val_i;
                    op2_d   = bus.is_rtype_i ? bus.rs2_val_i : bus.imm_i;
                    ctrl_d  = dec_ctrl;
                    flag_d  = dec_illegal;
                    cnt_d   = (dec_ctrl == CTRL_MUL) ? MUL_LOAD : 4'd0;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                // The ALU path is multicycle for MUL; only sample once the count has drained.
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    result_d  = flag_q ? 32'd0 : bus.alu_result_i;
                    illegal_d = flag_q;
                    state_d   = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            cnt_q     <= 4'd0;
            op1_q     <= 32'd0;
            op2_q     <= 32'd0;
            ctrl_q    <= CTRL_AND;
            flag_q    <= 1'b0;
            result_q  <= 32'd0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            op1_q     <= op1_d;
            op2_q     <= op2_d;
            ctrl_q    <= ctrl_d;
            flag_q    <= flag_d;
            result_q  <= result_d;
            illegal_q <= illegal_d;
        end
    end

    assign bus.in_ready_o     = (state_q == IDLE);
    assign bus.out_valid_o    = (state_q == DONE);
    assign bus.alu_operand1_o = op1_q;
    assign bus.alu_operand2_o = op2_q;
    assign bus.alu_ctrl_o     = ctrl_q;
    assign bus.result_o       = result_q;
    assign bus.illegal_o      = illegal_q;

endmodule
